// File: rtl/fir_param.sv
// rtl/fir_param.sv - parameterised FIR filter with AXI-Lite control and stream data path
module fir_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 12,
   parameter int MAX_TAPS = 32
) (
   input  logic              axis_clk,
   input  logic              axis_rst,
   input  logic              awvalid,
   output logic              awready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              wvalid,
   output logic              wready,
   input  logic [DATA_W-1:0] wdata,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ADDR_W-1:0] araddr,
   output logic              rvalid,
   input  logic              rready,
   output logic [DATA_W-1:0] rdata,
   input  logic              ss_tvalid,
   input  logic [DATA_W-1:0] ss_tdata,
   input  logic              ss_tlast,
   output logic              ss_tready,
   output logic              sm_tvalid,
   output logic [DATA_W-1:0] sm_tdata,
   output logic              sm_tlast,
   input  logic              sm_tready
);

   localparam int ACC_W = 2 * DATA_W + 5;
   localparam int IDX_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
   localparam int TAP_W = $clog2(MAX_TAPS) + 1;

   localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'('h00);
   localparam logic [ADDR_W-1:0] A_LEN     = ADDR_W'('h10);
   localparam logic [ADDR_W-1:0] A_TAPS    = ADDR_W'('h14);
   localparam logic [ADDR_W-1:0] A_MODE    = ADDR_W'('h18);
   localparam logic [ADDR_W-1:0] A_COEF_LO = ADDR_W'('h80);
   localparam logic [ADDR_W-1:0] A_COEF_HI = ADDR_W'('h80 + 4 * MAX_TAPS);

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IN,
      S_MAC,
      S_OUT,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   // configuration
   logic [DATA_W-1:0]        data_len;
   logic [TAP_W-1:0]         tap_len;
   logic                     sat_en;
   logic [5:0]               sh;
   logic signed [DATA_W-1:0] coef  [MAX_TAPS];

   // data path
   logic signed [DATA_W-1:0] xline [MAX_TAPS];
   logic signed [ACC_W-1:0]  acc;
   logic [TAP_W-1:0]         mac_idx;
   logic [DATA_W-1:0]        in_cnt;
   logic [DATA_W-1:0]        out_cnt;
   logic                     last_in;
   logic                     tlast_q;
   logic                     ap_done;
   logic                     ap_idle;

   // bus bookkeeping
   logic                     rd_ctrl;
   logic [DATA_W-1:0]        rd_mux;
   logic [TAP_W-1:0]         tap_wr;

   logic                     wr_fire;
   logic                     ar_fire;
   logic                     rd_done;
   logic                     cfg_we;
   logic                     start_fire;
   logic                     mac_last;
   logic                     tlast_next;

   logic [IDX_W-1:0]         mac_sel;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  shifted;
   logic [DATA_W-1:0]        res_data;

   function automatic logic coef_hit(input logic [ADDR_W-1:0] a);
      return (a >= A_COEF_LO) && (a < A_COEF_HI) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [IDX_W-1:0] coef_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - A_COEF_LO;
      return off[IDX_W+1:2];
   endfunction

   assign wr_fire    = awvalid && wvalid && awready && wready;
   assign ar_fire    = arvalid && arready;
   assign rd_done    = rvalid && rready;
   assign cfg_we     = wr_fire && ap_idle;
   assign start_fire = wr_fire && (awaddr == A_CTRL) && wdata[0] && ap_idle;

   assign mac_sel    = mac_idx[IDX_W-1:0];
   assign mac_last   = (mac_idx == tap_len - TAP_W'(1));
   assign prod       = coef[mac_sel] * xline[mac_sel];
   assign acc_next   = acc + $signed({{5{prod[2*DATA_W-1]}}, prod});
   assign shifted    = acc_next >>> sh;
   assign tlast_next = ((out_cnt + DATA_W'(1)) == data_len) || last_in;

   // Clamp a tap_len write into 1..MAX_TAPS.
   always_comb begin
      tap_wr = wdata[TAP_W-1:0];
      if (wdata == '0)
         tap_wr = TAP_W'(1);
      else if (wdata > DATA_W'(MAX_TAPS))
         tap_wr = TAP_W'(MAX_TAPS);
   end

   // Scale the final sum and either saturate or wrap it to DATA_W.
   always_comb begin
      res_data = shifted[DATA_W-1:0];
      if (sat_en) begin
         if (shifted > SAT_MAX)
            res_data = {1'b0, {(DATA_W-1){1'b1}}};
         else if (shifted < SAT_MIN)
            res_data = {1'b1, {(DATA_W-1){1'b0}}};
      end
   end

   // Register read decode; coefficients are hidden while a frame runs.
   always_comb begin
      rd_mux = '0;
      if (araddr == A_CTRL)
         rd_mux = DATA_W'({ap_idle, ap_done, 1'b0});
      else if (araddr == A_LEN)
         rd_mux = data_len;
      else if (araddr == A_TAPS)
         rd_mux = DATA_W'(tap_len);
      else if (araddr == A_MODE)
         rd_mux = DATA_W'({sh, sat_en});
      else if (coef_hit(araddr) && ap_idle)
         rd_mux = coef[coef_idx(araddr)];
   end

   // State register.
   always_ff @(posedge axis_clk) begin
      if (axis_rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start_fire)
               state_nxt = (data_len == '0) ? S_DONE : S_WAIT_IN;
         end
         S_WAIT_IN: if (ss_tvalid) state_nxt = S_MAC;
         S_MAC:     if (mac_last)  state_nxt = S_OUT;
         S_OUT: begin
            if (sm_tready)
               state_nxt = tlast_q ? S_DONE : S_WAIT_IN;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      ap_idle   = (state == S_IDLE) || (state == S_DONE);
      ss_tready = (state == S_WAIT_IN);
      sm_tvalid = (state == S_OUT);
      sm_tlast  = (state == S_OUT) && tlast_q;
   end

   // AXI-Lite handshakes: single-cycle ready pulses, read data held until rready.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         awready <= 1'b0;
         wready  <= 1'b0;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
         rd_ctrl <= 1'b0;
      end else begin
         awready <= awvalid && wvalid && !awready;
         wready  <= awvalid && wvalid && !awready;
         arready <= arvalid && !rvalid && !arready;
         if (ar_fire) begin
            rvalid  <= 1'b1;
            rdata   <= rd_mux;
            rd_ctrl <= (araddr == A_CTRL);
         end else if (rd_done) begin
            rvalid  <= 1'b0;
         end
      end
   end

   // Configuration registers, writable only while idle.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         data_len <= '0;
         tap_len  <= TAP_W'(MAX_TAPS);
         sat_en   <= 1'b0;
         sh       <= '0;
         for (int i = 0; i < MAX_TAPS; i++)
            coef[i] <= '0;
      end else if (cfg_we) begin
         if (awaddr == A_LEN)
            data_len <= wdata;
         if (awaddr == A_TAPS)
            tap_len <= tap_wr;
         if (awaddr == A_MODE) begin
            sat_en <= wdata[0];
            sh     <= wdata[6:1];
         end
         if (coef_hit(awaddr))
            coef[coef_idx(awaddr)] <= wdata;
      end
   end

   // Delay line, serial MAC, output register and frame status.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         for (int i = 0; i < MAX_TAPS; i++)
            xline[i] <= '0;
         acc      <= '0;
         mac_idx  <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         last_in  <= 1'b0;
         tlast_q  <= 1'b0;
         sm_tdata <= '0;
         ap_done  <= 1'b0;
      end else begin
         if (rd_done && rd_ctrl)
            ap_done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start_fire) begin
                  for (int i = 0; i < MAX_TAPS; i++)
                     xline[i] <= '0;
                  acc     <= '0;
                  mac_idx <= '0;
                  in_cnt  <= '0;
                  out_cnt <= '0;
                  last_in <= 1'b0;
                  tlast_q <= 1'b0;
                  ap_done <= (data_len == '0);
               end
            end
            S_WAIT_IN: begin
               if (ss_tvalid) begin
                  xline[0] <= ss_tdata;
                  for (int i = MAX_TAPS - 1; i > 0; i--)
                     xline[i] <= xline[i-1];
                  last_in <= ss_tlast;
                  in_cnt  <= in_cnt + DATA_W'(1);
                  acc     <= '0;
                  mac_idx <= '0;
               end
            end
            S_MAC: begin
               acc     <= acc_next;
               mac_idx <= mac_idx + TAP_W'(1);
               if (mac_last) begin
                  sm_tdata <= res_data;
                  tlast_q  <= tlast_next;
               end
            end
            S_OUT: begin
               if (sm_tready) begin
                  out_cnt <= out_cnt + DATA_W'(1);
                  if (tlast_q)
                     ap_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_param.sv
// tb/tb_fir_param.sv - directed self-checking bench for fir_param
module tb_fir_param;

   logic        axis_clk  = 1'b0;
   logic        axis_rst  = 1'b1;
   logic        awvalid   = 1'b0;
   logic        awready;
   logic [11:0] awaddr    = '0;
   logic        wvalid    = 1'b0;
   logic        wready;
   logic [31:0] wdata     = '0;
   logic        arvalid   = 1'b0;
   logic        arready;
   logic [11:0] araddr    = '0;
   logic        rvalid;
   logic        rready    = 1'b0;
   logic [31:0] rdata;
   logic        ss_tvalid = 1'b0;
   logic [31:0] ss_tdata  = '0;
   logic        ss_tlast  = 1'b0;
   logic        ss_tready;
   logic        sm_tvalid;
   logic [31:0] sm_tdata;
   logic        sm_tlast;
   logic        sm_tready = 1'b1;

   int total = 0;
   int bad   = 0;

   fir_param dut (
      .axis_clk (axis_clk),
      .axis_rst (axis_rst),
      .awvalid  (awvalid),
      .awready  (awready),
      .awaddr   (awaddr),
      .wvalid   (wvalid),
      .wready   (wready),
      .wdata    (wdata),
      .arvalid  (arvalid),
      .arready  (arready),
      .araddr   (araddr),
      .rvalid   (rvalid),
      .rready   (rready),
      .rdata    (rdata),
      .ss_tvalid(ss_tvalid),
      .ss_tdata (ss_tdata),
      .ss_tlast (ss_tlast),
      .ss_tready(ss_tready),
      .sm_tvalid(sm_tvalid),
      .sm_tdata (sm_tdata),
      .sm_tlast (sm_tlast),
      .sm_tready(sm_tready)
   );

   always #5 axis_clk = ~axis_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
      bit seen;
      seen = 0;
      @(negedge axis_clk);
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge axis_clk);
         if (awready && wready) begin seen = 1; break; end
      end
      @(posedge axis_clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      total++;
      if (!seen) begin bad++; $display("FAIL write_handshake addr=%h got=timeout exp=awready&wready", a); end
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
      bit seen;
      seen = 0;
      @(negedge axis_clk);
      araddr = a; arvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge axis_clk);
         if (arready) begin seen = 1; break; end
      end
      @(posedge axis_clk); #1;
      arvalid = 1'b0;
      d = rdata;
      total++;
      if (!seen || !rvalid) begin bad++; $display("FAIL read_handshake addr=%h arready=%b rvalid=%b exp=1", a, seen, rvalid); end
      rready = 1'b1;
      @(posedge axis_clk); #1;
      rready = 1'b0;
   endtask

   task automatic send(input logic [31:0] x, input logic last);
      bit seen;
      seen = 0;
      @(negedge axis_clk);
      ss_tdata = x; ss_tlast = last; ss_tvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (ss_tready) begin seen = 1; break; end
         @(negedge axis_clk);
      end
      @(posedge axis_clk); #1;
      ss_tvalid = 1'b0; ss_tlast = 1'b0;
      total++;
      if (!seen) begin bad++; $display("FAIL ss_handshake got=timeout exp=ss_tready"); end
   endtask

   task automatic recv(output logic [31:0] y, output logic l, output int lat);
      bit seen;
      seen = 0;
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge axis_clk);
         lat++;
         if (sm_tvalid) begin seen = 1; break; end
      end
      y = sm_tdata;
      l = sm_tlast;
      @(posedge axis_clk); #1;
      total++;
      if (!seen) begin bad++; $display("FAIL sm_valid got=timeout exp=sm_tvalid"); end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(posedge axis_clk);
      #1 axis_rst = 1'b0;
      @(negedge axis_clk);
      total++; if (ss_tready !== 1'b0) begin bad++; $display("FAIL rst_ss_tready got=%b exp=0", ss_tready); end
      total++; if (sm_tvalid !== 1'b0) begin bad++; $display("FAIL rst_sm_tvalid got=%b exp=0", sm_tvalid); end
      total++; if (sm_tlast !== 1'b0) begin bad++; $display("FAIL rst_sm_tlast got=%b exp=0", sm_tlast); end
      total++; if (sm_tdata !== 32'h0) begin bad++; $display("FAIL rst_sm_tdata got=%h exp=0", sm_tdata); end
      total++; if ({awready, wready, arready, rvalid} !== 4'b0) begin bad++; $display("FAIL rst_bus got=%b exp=0000", {awready, wready, arready, rvalid}); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
      axi_read(12'h000, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL rst_ctrl got=%h exp=4", d); end
      axi_read(12'h014, d);
      total++; if (d !== 32'd32) begin bad++; $display("FAIL rst_tap_len got=%h exp=20", d); end
      axi_read(12'h010, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_data_len got=%h exp=0", d); end
      axi_read(12'h018, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mode got=%h exp=0", d); end
      axi_read(12'h080, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_coef0 got=%h exp=0", d); end
      axi_read(12'h040, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", d); end
   endtask

   task automatic test_tap_clamp();
      logic [31:0] d;
      axi_write(12'h014, 32'd0);
      axi_read(12'h014, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL tap_len_zero got=%0d exp=1", d); end
      axi_write(12'h014, 32'd100);
      axi_read(12'h014, d);
      total++; if (d !== 32'd32) begin bad++; $display("FAIL tap_len_over got=%0d exp=32", d); end
      axi_write(12'h014, 32'd5);
      axi_read(12'h014, d);
      total++; if (d !== 32'd5) begin bad++; $display("FAIL tap_len_mid got=%0d exp=5", d); end
   endtask

   task automatic test_basic();
      logic [31:0] xs [4];
      logic [31:0] ys [4];
      logic [31:0] y;
      logic [31:0] d;
      logic        l;
      int          lat;
      xs = '{32'd1, 32'd2, 32'd3, 32'd4};
      ys = '{32'd1, 32'd4, 32'd10, 32'd20};
      for (int i = 0; i < 8; i++)
         axi_write(12'(12'h080 + 4 * i), 32'(i + 1));
      axi_write(12'h014, 32'd8);
      axi_write(12'h010, 32'd4);
      axi_write(12'h018, 32'd0);
      axi_write(12'h000, 32'd1);
      for (int n = 0; n < 4; n++) begin
         send(xs[n], 1'b0);
         recv(y, l, lat);
         total++; if (y !== ys[n]) begin bad++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", n, y, ys[n]); end
         total++; if (l !== (n == 3)) begin bad++; $display("FAIL basic_tlast[%0d] got=%b exp=%b", n, l, (n == 3)); end
         total++; if (lat != 9) begin bad++; $display("FAIL basic_latency[%0d] got=%0d exp=9", n, lat); end
      end
      axi_read(12'h000, d);
      total++; if (d !== 32'h6) begin bad++; $display("FAIL basic_ctrl_done got=%h exp=6", d); end
      axi_read(12'h000, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL basic_ctrl_clear got=%h exp=4", d); end
   endtask

   task automatic test_saturate();
      logic [31:0] y;
      logic        l;
      int          lat;
      axi_write(12'h080, 32'h7FFF_FFFF);
      axi_write(12'h014, 32'd1);
      axi_write(12'h010, 32'd1);
      axi_write(12'h018, 32'd1);
      axi_write(12'h000, 32'd1);
      send(32'd2, 1'b0);
      recv(y, l, lat);
      total++; if (y !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos got=%h exp=7fffffff", y); end
      total++; if (l !== 1'b1) begin bad++; $display("FAIL sat_tlast got=%b exp=1", l); end
      total++; if (lat != 2) begin bad++; $display("FAIL sat_latency got=%0d exp=2", lat); end
      axi_write(12'h000, 32'd1);
      send(32'hFFFF_FFFE, 1'b0);
      recv(y, l, lat);
      total++; if (y !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg got=%h exp=80000000", y); end
      axi_write(12'h018, 32'd0);
      axi_write(12'h000, 32'd1);
      send(32'd2, 1'b0);
      recv(y, l, lat);
      total++; if (y !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap got=%h exp=fffffffe", y); end
      axi_write(12'h080, 32'd3);
      axi_write(12'h018, 32'd2);
      axi_write(12'h000, 32'd1);
      send(32'hFFFF_FFFA, 1'b0);
      recv(y, l, lat);
      total++; if (y !== 32'hFFFF_FFF7) begin bad++; $display("FAIL shift_arith got=%h exp=fffffff7", y); end
   endtask

   task automatic test_early_last();
      logic [31:0] y;
      logic [31:0] d;
      logic        l;
      int          lat;
      axi_write(12'h080, 32'd1);
      axi_write(12'h014, 32'd1);
      axi_write(12'h010, 32'd10);
      axi_write(12'h018, 32'd0);
      axi_write(12'h000, 32'd1);
      for (int n = 0; n < 3; n++) begin
         send(32'(n + 3), (n == 2));
         recv(y, l, lat);
         total++; if (y !== 32'(n + 3)) begin bad++; $display("FAIL early_data[%0d] got=%0d exp=%0d", n, y, n + 3); end
         total++; if (l !== (n == 2)) begin bad++; $display("FAIL early_tlast[%0d] got=%b exp=%b", n, l, (n == 2)); end
      end
      @(negedge axis_clk);
      total++; if (ss_tready !== 1'b0) begin bad++; $display("FAIL early_done_tready got=%b exp=0", ss_tready); end
      axi_read(12'h000, d);
      total++; if (d !== 32'h6) begin bad++; $display("FAIL early_ctrl got=%h exp=6", d); end
   endtask

   task automatic test_backpressure();
      logic [31:0] y;
      logic        l;
      int          lat;
      bit          seen;
      axi_write(12'h080, 32'd1);
      axi_write(12'h084, 32'd1);
      axi_write(12'h014, 32'd2);
      axi_write(12'h010, 32'd2);
      axi_write(12'h000, 32'd1);
      sm_tready = 1'b0;
      send(32'd5, 1'b0);
      recv(y, l, lat);
      total++; if (y !== 32'd5) begin bad++; $display("FAIL bp_first got=%0d exp=5", y); end
      ss_tdata = 32'd7; ss_tvalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge axis_clk);
         total++; if (sm_tvalid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, sm_tvalid); end
         total++; if (sm_tdata !== 32'd5) begin bad++; $display("FAIL bp_data[%0d] got=%0d exp=5", c, sm_tdata); end
         total++; if (ss_tready !== 1'b0) begin bad++; $display("FAIL bp_ss_tready[%0d] got=%b exp=0", c, ss_tready); end
      end
      sm_tready = 1'b1;
      @(posedge axis_clk); #1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge axis_clk);
         if (ss_tready) begin seen = 1; break; end
      end
      @(posedge axis_clk); #1;
      ss_tvalid = 1'b0;
      total++; if (!seen) begin bad++; $display("FAIL bp_resume got=timeout exp=ss_tready"); end
      recv(y, l, lat);
      total++; if (y !== 32'd12) begin bad++; $display("FAIL bp_second got=%0d exp=12", y); end
      total++; if (l !== 1'b1) begin bad++; $display("FAIL bp_tlast got=%b exp=1", l); end
   endtask

   task automatic test_busy_write();
      logic [31:0] y;
      logic [31:0] d;
      logic        l;
      int          lat;
      axi_write(12'h080, 32'd9);
      axi_write(12'h014, 32'd1);
      axi_write(12'h010, 32'd1);
      axi_write(12'h000, 32'd1);
      axi_write(12'h080, 32'h55);
      axi_write(12'h014, 32'd4);
      axi_read(12'h080, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL busy_coef_read got=%h exp=0", d); end
      send(32'd2, 1'b0);
      recv(y, l, lat);
      total++; if (y !== 32'd18) begin bad++; $display("FAIL busy_data got=%0d exp=18", y); end
      total++; if (lat != 2) begin bad++; $display("FAIL busy_latency got=%0d exp=2", lat); end
      axi_read(12'h080, d);
      total++; if (d !== 32'd9) begin bad++; $display("FAIL busy_coef_kept got=%0d exp=9", d); end
      axi_read(12'h014, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL busy_tap_kept got=%0d exp=1", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] y;
      logic [31:0] d;
      logic        l;
      int          lat;
      axi_write(12'h014, 32'd8);
      axi_write(12'h010, 32'd4);
      axi_write(12'h000, 32'd1);
      send(32'd100, 1'b0);
      @(negedge axis_clk);
      @(negedge axis_clk);
      axis_rst = 1'b1;
      @(posedge axis_clk); #1;
      axis_rst = 1'b0;
      total++; if (ss_tready !== 1'b0) begin bad++; $display("FAIL mid_rst_ss_tready got=%b exp=0", ss_tready); end
      total++; if (sm_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_sm_tvalid got=%b exp=0", sm_tvalid); end
      total++; if (sm_tdata !== 32'h0) begin bad++; $display("FAIL mid_rst_sm_tdata got=%h exp=0", sm_tdata); end
      total++; if (sm_tlast !== 1'b0) begin bad++; $display("FAIL mid_rst_sm_tlast got=%b exp=0", sm_tlast); end
      total++; if ({awready, wready, arready, rvalid} !== 4'b0) begin bad++; $display("FAIL mid_rst_bus got=%b exp=0000", {awready, wready, arready, rvalid}); end
      axi_read(12'h000, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL mid_rst_ctrl got=%h exp=4", d); end
      axi_read(12'h014, d);
      total++; if (d !== 32'd32) begin bad++; $display("FAIL mid_rst_tap_len got=%0d exp=32", d); end
      axi_read(12'h080, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_rst_coef got=%h exp=0", d); end
      axi_write(12'h080, 32'd1);
      axi_write(12'h084, 32'd1);
      axi_write(12'h014, 32'd2);
      axi_write(12'h010, 32'd2);
      axi_write(12'h000, 32'd1);
      send(32'd3, 1'b0);
      recv(y, l, lat);
      total++; if (y !== 32'd3) begin bad++; $display("FAIL clean_first got=%0d exp=3", y); end
      send(32'd4, 1'b0);
      recv(y, l, lat);
      total++; if (y !== 32'd7) begin bad++; $display("FAIL clean_second got=%0d exp=7", y); end
      total++; if (l !== 1'b1) begin bad++; $display("FAIL clean_tlast got=%b exp=1", l); end
      axi_read(12'h000, d);
      axi_read(12'h000, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL clean_ctrl got=%h exp=4", d); end
      axi_write(12'h010, 32'd0);
      axi_write(12'h000, 32'd1);
      axi_read(12'h000, d);
      total++; if (d !== 32'h6) begin bad++; $display("FAIL zero_len_done got=%h exp=6", d); end
   endtask

   initial begin
      test_reset();
      test_tap_clamp();
      test_basic();
      test_saturate();
      test_early_last();
      test_backpressure();
      test_busy_write();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_param.md
FIR_PARAM -- requirements
Module: fir_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: sample, coefficient and AXI data width.
REQ-002 SHALL have parameter ADDR_W, default 12: AXI-Lite address width.
REQ-003 SHALL have parameter MAX_TAPS, default 32: tap storage depth; power of two, at most 32.
REQ-004 SHALL have port axis_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port axis_rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have AXI-Lite write ports: awvalid in 1, awready out 1, awaddr in ADDR_W, wvalid in 1, wready out 1, wdata in DATA_W.
REQ-007 SHALL have AXI-Lite read ports: arvalid in 1, arready out 1, araddr in ADDR_W, rvalid out 1, rready in 1, rdata out DATA_W.
REQ-008 SHALL have input stream ports: ss_tvalid in 1, ss_tdata in DATA_W, ss_tlast in 1, ss_tready out 1.
REQ-009 SHALL have output stream ports: sm_tvalid out 1, sm_tdata out DATA_W, sm_tlast out 1, sm_tready in 1.

Function
REQ-010 SHALL use this register map:
- 0x00 ctrl: bit0 ap_start (write 1, self-clearing), bit1 ap_done (RO), bit2 ap_idle (RO).
- 0x10 data_len.
- 0x14 tap_len, valid range 1..MAX_TAPS; a write of 0 stores 1, a write above MAX_TAPS stores MAX_TAPS.
- 0x18 mode: bit0 sat_en; bits[6:1] shift amount sh.
- 0x80+4*i: coefficient h[i], i < MAX_TAPS.
REQ-011 SHALL keep coefficients and the delay line x[0..MAX_TAPS-1] in internal registers; no external RAM.
REQ-012 Write handshake: SHALL assert awready and wready together for exactly one cycle, only when awvalid and wvalid are both high, and commit wdata in that cycle.
REQ-013 Read handshake:
- SHALL assert arready for one cycle when arvalid is high and rvalid is low.
- SHALL assert rvalid the following cycle, holding rdata stable until rready.
REQ-014 Writes to 0x10, 0x14, 0x18 and coefficients while ap_idle=0 SHALL complete the handshake but not change state; tap reads while busy SHALL return 0; unmapped reads SHALL return 0.
REQ-015 SHALL implement FSM states IDLE, WAIT_IN, MAC, OUT and DONE.
REQ-016 IDLE/DONE -> WAIT_IN on ap_start write:
- clear delay line, accumulator, in_cnt and out_cnt;
- clear ap_done and ap_idle;
- if data_len==0, go to DONE directly instead.
REQ-017 WAIT_IN: SHALL hold ss_tready=1; on ss_tvalid&&ss_tready, shift the delay line (x[0]<=ss_tdata, x[i]<=x[i-1]), latch ss_tlast, increment in_cnt, and go to MAC.
REQ-018 MAC: SHALL take exactly tap_len cycles, one product per cycle, acc += signed h[i]*x[i] for i = 0..tap_len-1, then go to OUT.
REQ-019 The accumulator SHALL be 2*DATA_W+5 bits signed; result r = acc >>> sh (arithmetic).
REQ-020 OUT: SHALL drive sm_tvalid=1 with sm_tdata stable until sm_tready:
- sat_en=1: r clamped to the signed DATA_W range;
- sat_en=0: r truncated to the low DATA_W bits.
REQ-021 sm_tlast SHALL be 1 on the output where out_cnt+1==data_len or the latched ss_tlast was 1, whichever comes first.
REQ-022 On the OUT handshake: if sm_tlast, go to DONE with ap_done=1 and ap_idle=1; else go to WAIT_IN.
REQ-023 Latency SHALL be tap_len+1 cycles from input handshake to first sm_tvalid; throughput is one sample per tap_len+2 cycles with sm_tready held high.
REQ-024 ap_done SHALL clear on the rvalid&&rready handshake of a 0x00 read; ap_start writes while not idle SHALL be ignored.
REQ-025 ss_tready SHALL be 0 outside WAIT_IN; sm_tvalid SHALL be 0 outside OUT.

Reset
REQ-026 axis_rst=1 at any clock edge, including mid-frame, SHALL force:
- state IDLE, ap_idle=1, ap_done=0;
- ss_tready, sm_tvalid, sm_tlast, awready, wready, arready and rvalid all 0;
- sm_tdata=0, rdata=0;
- tap_len=MAX_TAPS, data_len=0, mode=0;
- coefficients and delay line 0.

Verification
REQ-027 Taps h=1..8, tap_len=8, data_len=4, sh=0, inputs 1,2,3,4 -> outputs 1,4,10,20; sm_tlast only on 20; ctrl read returns 0x6, then 0x4.
REQ-028 sat_en=1, h[0]=0x7FFFFFFF, tap_len=1, input 2 -> 0x7FFFFFFF; same with sat_en=0 -> 0xFFFFFFFE.
REQ-029 data_len=10, ss_tlast on the 3rd input -> exactly 3 outputs, sm_tlast on the 3rd, then DONE.
REQ-030 sm_tready held low for 5 cycles in OUT -> sm_tvalid and sm_tdata stable, ss_tready stays 0, no input lost.
REQ-031 Coefficient write to 0x80 while busy -> handshake completes, h[0] unchanged; readback after DONE shows the old value.
REQ-032 axis_rst pulsed during MAC -> all outputs at reset values next cycle; a new ap_start then runs a clean frame with no stale samples.
